// File: rtl/key_conditioner.sv
// key_conditioner
// Front-end conditioning for the serial multiplier processor. Raw active-low
// pushbuttons are double-flop synchronized, debounced and turned into a clean
// pressed level plus one-cycle press/release pulses. Slide switches are
// double-flop synchronized only.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   key_n        raw pushbuttons, active-low, asynchronous
//   sw_raw       raw slide switches, asynchronous
//   key_level    debounced key state, 1 = pressed
//   key_press    one-cycle pulse on key_level 0->1
//   key_release  one-cycle pulse on key_level 1->0
//   sw_sync      synchronized switch value (sw_raw delayed 2 edges)
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [SW_WIDTH-1:0] sw_sync
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Key chain works on the inverted (active-high) key, so the reset value 0
  // means "released" in both stages.
  logic [NUM_KEYS-1:0] key_meta_r;
  logic [NUM_KEYS-1:0] key_sync_r;
  logic [SW_WIDTH-1:0] sw_meta_r;
  logic [CW-1:0]       cnt_r [NUM_KEYS];

  logic [NUM_KEYS-1:0] differ_s;
  logic [NUM_KEYS-1:0] expire_s;

  // A key is ready to change once it has disagreed with the level for the
  // full debounce window; the counter holds the number of disagreeing
  // samples seen so far, so the final disagreeing sample arrives at CNT_LAST.
  always_comb begin
    differ_s = key_sync_r ^ key_level;
    expire_s = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (differ_s[i] && (cnt_r[i] == CNT_LAST)) begin
        expire_s[i] = 1'b1;
      end else begin
        expire_s[i] = 1'b0;
      end
    end
  end

  // Synchronizers, debounce counters, level and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_r  <= '0;
      key_sync_r  <= '0;
      sw_meta_r   <= '0;
      sw_sync     <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      key_meta_r <= ~key_n;
      key_sync_r <= key_meta_r;
      sw_meta_r  <= sw_raw;
      sw_sync    <= sw_meta_r;

      // Counter clears on any agreeing sample (bounce restarts the window)
      // and on acceptance, so it can never exceed CNT_LAST.
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!differ_s[i] || expire_s[i]) begin
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end

      key_level   <= key_level ^ expire_s;
      key_press   <= expire_s & key_sync_r;
      key_release <= expire_s & ~key_sync_r;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner (DEBOUNCE_CYCLES = 4).
// Stimulus pushes the expected per-cycle outputs into a scoreboard queue from
// a behavioural model; a monitor on the falling edge pops and compares.
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int SW = 8;
  localparam int D  = 4;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic [NK-1:0] key_n  = 3'b111;
  logic [SW-1:0] sw_raw = 8'hFF;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [SW-1:0] sw_sync;

  key_conditioner #(
    .NUM_KEYS(NK),
    .SW_WIDTH(SW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .sw_raw(sw_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .sw_sync(sw_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [SW-1:0] sw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pcnt[NK];
  int   rcnt[NK];
  int   pair02 = 0;

  // Behavioural model: raw values reach the debouncer two edges late; a key's
  // level flips once the last D samples since its previous flip all disagree.
  logic [NK-1:0] m_d1 = '0, m_d2 = '0, m_level = '0;
  logic [SW-1:0] m_s1 = '0, m_s2 = '0;
  logic [31:0]   m_hist[NK];
  int            m_age[NK];

  task automatic model_edge();
    exp_t          e;
    logic [NK-1:0] v;
    logic [D-1:0]  want;
    e.press = '0;
    e.rel   = '0;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < NK; i++) begin
        m_hist[i] = '0;
        m_age[i]  = 0;
      end
    end else begin
      v    = m_d2;
      m_d2 = m_d1;
      m_d1 = ~key_n;
      m_s2 = m_s1;
      m_s1 = sw_raw;
      for (int i = 0; i < NK; i++) begin
        m_hist[i] = {m_hist[i][30:0], v[i]};
        m_age[i]++;
        want = {D{~m_level[i]}};
        if (m_age[i] >= D && m_hist[i][D-1:0] == want) begin
          m_level[i] = ~m_level[i];
          if (m_level[i]) e.press[i] = 1'b1;
          else            e.rel[i]   = 1'b1;
          m_age[i] = 0;
        end
      end
    end
    e.level = m_level;
    e.sw    = m_s2;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every cycle's outputs against the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (key_level !== mon_e.level) begin
        errors++;
        $display("FAIL sb_level: got %b expected %b at %0t", key_level, mon_e.level, $time);
      end
      checks++;
      if (key_press !== mon_e.press) begin
        errors++;
        $display("FAIL sb_press: got %b expected %b at %0t", key_press, mon_e.press, $time);
      end
      checks++;
      if (key_release !== mon_e.rel) begin
        errors++;
        $display("FAIL sb_release: got %b expected %b at %0t", key_release, mon_e.rel, $time);
      end
      checks++;
      if (sw_sync !== mon_e.sw) begin
        errors++;
        $display("FAIL sb_sw: got %h expected %h at %0t", sw_sync, mon_e.sw, $time);
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   pcnt[i]++;
      if (key_release[i]) rcnt[i]++;
    end
    if (key_press[0] && key_press[2]) pair02++;
  end

  int p0, p1, p2, r0, pr;
  int hold[NK];

  initial begin
    for (int i = 0; i < NK; i++) begin
      pcnt[i] = 0; rcnt[i] = 0; m_hist[i] = '0; m_age[i] = 0; hold[i] = 0;
    end
    @(negedge clk); #1;

    // Reset
    ticks(2);
    check("rst_level", int'(key_level), 0);
    check("rst_press", int'(key_press), 0);
    check("rst_release", int'(key_release), 0);
    check("rst_sw", int'(sw_sync), 0);
    reset = 1'b0;
    ticks(1);
    check("sw_after_1", int'(sw_sync), 0);
    ticks(1);
    check("sw_after_2", int'(sw_sync), 8'hFF);
    ticks(4);

    // Clean press / release on key 0
    p0 = pcnt[0];
    key_n[0] = 1'b0;
    ticks(5);
    check("press0_early", pcnt[0] - p0, 0);
    ticks(1);
    check("press0_at_6", int'(key_press[0]), 1);
    check("level0_at_6", int'(key_level[0]), 1);
    ticks(14);
    check("press0_once", pcnt[0] - p0, 1);
    r0 = rcnt[0];
    key_n[0] = 1'b1;
    ticks(5);
    check("release0_early", rcnt[0] - r0, 0);
    ticks(1);
    check("release0_at_6", int'(key_release[0]), 1);
    ticks(6);
    check("release0_once", rcnt[0] - r0, 1);
    check("level0_back", int'(key_level[0]), 0);

    // Bounce on key 1: low3/high1/low2/high1/low3, then held low
    p1 = pcnt[1];
    key_n[1] = 1'b0; ticks(3);
    key_n[1] = 1'b1; ticks(1);
    key_n[1] = 1'b0; ticks(2);
    key_n[1] = 1'b1; ticks(1);
    key_n[1] = 1'b0; ticks(3);
    check("bounce_no_press", pcnt[1] - p1, 0);
    check("bounce_level", int'(key_level[1]), 0);
    ticks(10);
    check("bounce_one_press", pcnt[1] - p1, 1);
    key_n[1] = 1'b1;
    ticks(10);

    // Simultaneous press of keys 0 and 2
    p0 = pcnt[0]; p1 = pcnt[1]; p2 = pcnt[2]; pr = pair02;
    key_n = 3'b010;
    ticks(10);
    check("simul_press0", pcnt[0] - p0, 1);
    check("simul_press2", pcnt[2] - p2, 1);
    check("simul_same_cycle", pair02 - pr, 1);
    check("simul_press1", pcnt[1] - p1, 0);
    key_n = 3'b111;
    ticks(10);

    // Switches
    sw_raw = 8'h3B; ticks(3);
    sw_raw = 8'hC5; ticks(5);

    // Reset mid-debounce
    p0 = pcnt[0];
    key_n[0] = 1'b0;
    ticks(3);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0;
    ticks(2);
    check("midrst_no_press", pcnt[0] - p0, 0);
    ticks(3);
    check("midrst_before_6", pcnt[0] - p0, 0);
    ticks(1);
    check("midrst_press_at_6", int'(key_press[0]), 1);
    ticks(15);
    check("midrst_once", pcnt[0] - p0, 1);
    key_n[0] = 1'b1;
    ticks(10);

    // Randomized phase
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          key_n[i] = ~key_n[i];
          hold[i]  = $urandom_range(1, 9);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 7) == 0) sw_raw = 8'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    ticks(12);
    @(negedge clk); #1;
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end conditioning stage for the 8-bit serial multiplier Processor. It sits between the board pushbuttons/slide switches and the processor control inputs.
- Synchronizes raw active-low keys, debounces them and produces a clean level plus single-cycle press/release pulses, so that one physical press of Clear_A/Load_B or Execute yields exactly one operation.
- Also double-flop synchronizes the 8 slide switches that feed the operand path.

Parameters:
- NUM_KEYS, 3, number of independent keys conditioned.
- SW_WIDTH, 8, slide switch bus width.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a change (5 ms at 50 MHz). Minimum legal value 2; benches override to 4.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- key_n  in  NUM_KEYS  raw pushbuttons, active-low, asynchronous to clk.
- sw_raw  in  SW_WIDTH  raw slide switches, asynchronous.
- key_level  out  NUM_KEYS  debounced key state, 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse when key_level goes 0->1.
- key_release  out  NUM_KEYS  one-cycle pulse when key_level goes 1->0.
- sw_sync  out  SW_WIDTH  synchronized switch value.

Behaviour:
- Reset (sampled on a clk rising edge while reset=1):
  - key sync flops = released.
  - debounce counters = 0.
  - key_level = 0, key_press = 0, key_release = 0.
  - sw_sync = 0 and both switch sync stages = 0.
- Synchronizer: 2-FF chain per key on ~key_n; the synchronized sample s[i] is valid after 2 edges. The same 2-FF chain applies to sw_raw; sw_sync equals sw_raw delayed 2 edges. Switches are not debounced.
- Debounce, per key, all keys independent:
  - Each key has a counter of width clog2(DEBOUNCE_CYCLES).
  - If s[i] == key_level[i], the counter clears to 0.
  - If s[i] != key_level[i] and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s[i] != key_level[i] and counter == DEBOUNCE_CYCLES-1: next edge key_level[i] <= s[i], counter <= 0, and the matching pulse (press if s[i]=1, release if s[i]=0) is registered high.
- Pulses are registered outputs, high for exactly one cycle, coincident with the first cycle of the new key_level.
- Latency: counting the edge that first samples a new stable raw value as edge 1, key_level and the pulse update on edge DEBOUNCE_CYCLES+2.
- Bounce: any single cycle where s[i] matches key_level[i] restarts the count. A glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
- key_press[i] and key_release[i] are never high together. Different keys may pulse in the same cycle.
- Reset mid-debounce discards the partial count and any pending pulse; no pulse is emitted during or on the edge after reset.
- A key held through reset deassertion is treated as a new press. Its pulse arrives DEBOUNCE_CYCLES+2 edges after the first non-reset edge. Downstream control accepts this.
- Counters saturate by construction and never wrap, because they clear on every level change.
- No combinational path from any input to any output.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, so latency is 6 edges.)
- Reset: key_n=3'b111, sw_raw=8'hFF, reset=1 for 2 edges. Required: key_level=0, key_press=0, key_release=0, sw_sync=8'h00. After reset drops, sw_sync=8'hFF on the 2nd edge.
- Clean press/release: key_n[0] driven low, sampled at edge E.
  - key_press[0]=1 only in the cycle after edge E+5; key_level[0]=1 from then on.
  - key_n[0] high 20 cycles later: key_release[0] pulses once, 6 edges after sampling; key_level[0] returns to 0.
- Bounce: key_n[1] pattern low3/high1/low2/high1/low3 cycles. Required: no pulse, key_level[1]=0. Then low held 10 cycles: exactly one key_press[1] at the 6th edge.
- Simultaneous keys: key_n[0] and key_n[2] dropped on the same edge. Required: key_press[0] and key_press[2] high in the same single cycle; key_press[1]=0.
- Switches: sw_raw 8'h3B, then 8'hC5 three cycles later. Required: sw_sync=8'h3B for exactly 3 cycles starting 2 edges after the first change, then 8'hC5, with no intermediate values.
- Reset mid-debounce: key_n[0] low at edge E, reset=1 at edge E+3 only.
  - No pulse at E+5.
  - With key still held, key_press[0] fires once on the 6th edge after reset deasserts.
  - No further pulses while held.
